// File: rtl/l1_mem_port_arbiter_pkg.sv
// Shared encodings and payload structs for the L1 D/I memory port arbiter.
package l1_mem_port_arbiter_pkg;

  localparam int P_ID_DEPTH_DEF = 16;
  localparam int P_MAX_BEAT_DEF = 8;

  localparam logic REQ_D0 = 1'b0;
  localparam logic REQ_I1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT_D0 = 2'd1,
    ST_GRANT_I1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [1:0]  order;
    logic [3:0]  mask;
    logic        rw;
    logic [13:0] tid;
    logic [1:0]  mmumod;
    logic [31:0] pdt;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_req_t;

  typedef struct packed {
    logic        pagefault;
    logic [27:0] mmu_flags;
    logic [63:0] data;
  } mem_rsp_t;

endpackage

// File: rtl/l1_mem_port_arbiter_id_fifo.sv
// Outstanding-request owner FIFO: one bit per in-flight memory request.
module l1_mem_port_arbiter_id_fifo #(
  parameter int P_DEPTH = 16
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic push_i,
  input  logic id_i,
  input  logic pop_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(P_DEPTH);
  localparam logic [AW:0] FULL_CNT = P_DEPTH[AW:0];

  logic [P_DEPTH-1:0] mem_q;
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        cnt_q;
  logic               push_ok, pop_ok;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= id_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop_ok) rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/l1_mem_port_arbiter.sv
// Shares the memory port between L1 D-cache (D0) and I-cache (I1) with atomic bursts.
// MIST1032ISA_MEMARB_DATA_PRIORITY_EN: D0 always wins an IDLE tie instead of round robin.
module l1_mem_port_arbiter
  import l1_mem_port_arbiter_pkg::*;
#(
  parameter int P_ID_DEPTH = P_ID_DEPTH_DEF,
  parameter int P_MAX_BEAT = P_MAX_BEAT_DEF
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iD0_REQ,
  output logic        oD0_LOCK,
  input  logic [1:0]  iD0_ORDER,
  input  logic [3:0]  iD0_MASK,
  input  logic        iD0_RW,
  input  logic [13:0] iD0_TID,
  input  logic [1:0]  iD0_MMUMOD,
  input  logic [31:0] iD0_PDT,
  input  logic [31:0] iD0_ADDR,
  input  logic [31:0] iD0_DATA,
  input  logic        iI1_REQ,
  output logic        oI1_LOCK,
  input  logic [1:0]  iI1_ORDER,
  input  logic [3:0]  iI1_MASK,
  input  logic        iI1_RW,
  input  logic [13:0] iI1_TID,
  input  logic [1:0]  iI1_MMUMOD,
  input  logic [31:0] iI1_PDT,
  input  logic [31:0] iI1_ADDR,
  input  logic [31:0] iI1_DATA,
  output logic        oD0_VALID,
  output logic        oD0_PAGEFAULT,
  output logic [27:0] oD0_MMU_FLAGS,
  output logic [63:0] oD0_DATA,
  output logic        oI1_VALID,
  output logic        oI1_PAGEFAULT,
  output logic [27:0] oI1_MMU_FLAGS,
  output logic [63:0] oI1_DATA,
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic [1:0]  oMEM_ORDER,
  output logic [3:0]  oMEM_MASK,
  output logic        oMEM_RW,
  output logic [13:0] oMEM_TID,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [31:0] oMEM_PDT,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic        iMEM_PAGEFAULT,
  input  logic [27:0] iMEM_MMU_FLAGS,
  input  logic [63:0] iMEM_DATA
);
  localparam int BW = (P_MAX_BEAT > 1) ? $clog2(P_MAX_BEAT) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(P_MAX_BEAT - 1);

  arb_state_e    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          last_q, last_d;

  mem_req_t d0_req, i1_req, mux_req;
  mem_rsp_t rsp;
  logic     grant_d0, grant_i1, own_req, accept, tie_to_i1;
  logic     fifo_full, fifo_empty, fifo_head, pop_ok;

  assign d0_req = {iD0_ORDER, iD0_MASK, iD0_RW, iD0_TID, iD0_MMUMOD, iD0_PDT, iD0_ADDR, iD0_DATA};
  assign i1_req = {iI1_ORDER, iI1_MASK, iI1_RW, iI1_TID, iI1_MMUMOD, iI1_PDT, iI1_ADDR, iI1_DATA};

  assign grant_d0 = (state_q == ST_GRANT_D0);
  assign grant_i1 = (state_q == ST_GRANT_I1);
  assign own_req  = (grant_d0 & iD0_REQ) | (grant_i1 & iI1_REQ);
  assign oMEM_REQ = own_req & ~fifo_full;
  assign accept   = oMEM_REQ & ~iMEM_LOCK;
  assign oD0_LOCK = ~grant_d0 | iMEM_LOCK | fifo_full;
  assign oI1_LOCK = ~grant_i1 | iMEM_LOCK | fifo_full;

  always_comb begin
    mux_req = '0;
    if (grant_d0)      mux_req = d0_req;
    else if (grant_i1) mux_req = i1_req;
  end

  assign {oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_TID, oMEM_MMUMOD,
          oMEM_PDT, oMEM_ADDR, oMEM_DATA} = mux_req;

`ifdef MIST1032ISA_MEMARB_DATA_PRIORITY_EN
  assign tie_to_i1 = 1'b0;
`else
  assign tie_to_i1 = (last_q == REQ_D0);
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iD0_REQ && iI1_REQ) state_d = tie_to_i1 ? ST_GRANT_I1 : ST_GRANT_D0;
        else if (iD0_REQ)       state_d = ST_GRANT_D0;
        else if (iI1_REQ)       state_d = ST_GRANT_I1;
      end
      ST_GRANT_D0, ST_GRANT_I1: begin
        // Burst ends when the owner lets go or its last allowed beat is taken.
        if (!own_req || (accept && beat_q == LAST_BEAT)) begin
          state_d = ST_IDLE;
          beat_d  = '0;
          last_d  = grant_i1;
        end else if (accept) begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      last_q  <= REQ_I1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
    end
  end

  l1_mem_port_arbiter_id_fifo #(.P_DEPTH(P_ID_DEPTH)) u_id_fifo (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .push_i  (accept),
    .id_i    (grant_i1),
    .pop_i   (iMEM_VALID),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Responses with nothing outstanding are orphans and are dropped silently.
  assign pop_ok    = iMEM_VALID & ~fifo_empty;
  assign oD0_VALID = pop_ok & (fifo_head == REQ_D0);
  assign oI1_VALID = pop_ok & (fifo_head == REQ_I1);
  assign rsp       = pop_ok ? {iMEM_PAGEFAULT, iMEM_MMU_FLAGS, iMEM_DATA} : '0;

  assign {oD0_PAGEFAULT, oD0_MMU_FLAGS, oD0_DATA} = rsp;
  assign {oI1_PAGEFAULT, oI1_MMU_FLAGS, oI1_DATA} = rsp;

endmodule

// File: tb/tb_l1_mem_port_arbiter.sv
// Randomized and directed bench for l1_mem_port_arbiter against a queue-based model.
`timescale 1ns/1ps
module tb_l1_mem_port_arbiter;
  import l1_mem_port_arbiter_pkg::*;

  localparam int DEPTH = 16;
  localparam int MAXB  = 8;

  logic iCLOCK  = 1'b0;
  logic inRESET = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  logic        d0_req = 1'b0, i1_req = 1'b0;
  mem_req_t    pl [2];
  logic        mem_lock = 1'b0, mem_valid = 1'b0, mem_pf = 1'b0;
  logic [27:0] mem_fl = '0;
  logic [63:0] mem_data = '0;

  logic        oD0_LOCK, oI1_LOCK, oD0_VALID, oI1_VALID, oMEM_REQ;
  logic        oD0_PAGEFAULT, oI1_PAGEFAULT;
  logic [27:0] oD0_MMU_FLAGS, oI1_MMU_FLAGS;
  logic [63:0] oD0_DATA, oI1_DATA;
  logic [1:0]  oMEM_ORDER, oMEM_MMUMOD;
  logic [3:0]  oMEM_MASK;
  logic        oMEM_RW;
  logic [13:0] oMEM_TID;
  logic [31:0] oMEM_PDT, oMEM_ADDR, oMEM_DATA;

  l1_mem_port_arbiter #(.P_ID_DEPTH(DEPTH), .P_MAX_BEAT(MAXB)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iD0_REQ(d0_req), .oD0_LOCK(oD0_LOCK),
    .iD0_ORDER(pl[0].order), .iD0_MASK(pl[0].mask), .iD0_RW(pl[0].rw), .iD0_TID(pl[0].tid),
    .iD0_MMUMOD(pl[0].mmumod), .iD0_PDT(pl[0].pdt), .iD0_ADDR(pl[0].addr), .iD0_DATA(pl[0].data),
    .iI1_REQ(i1_req), .oI1_LOCK(oI1_LOCK),
    .iI1_ORDER(pl[1].order), .iI1_MASK(pl[1].mask), .iI1_RW(pl[1].rw), .iI1_TID(pl[1].tid),
    .iI1_MMUMOD(pl[1].mmumod), .iI1_PDT(pl[1].pdt), .iI1_ADDR(pl[1].addr), .iI1_DATA(pl[1].data),
    .oD0_VALID(oD0_VALID), .oD0_PAGEFAULT(oD0_PAGEFAULT), .oD0_MMU_FLAGS(oD0_MMU_FLAGS), .oD0_DATA(oD0_DATA),
    .oI1_VALID(oI1_VALID), .oI1_PAGEFAULT(oI1_PAGEFAULT), .oI1_MMU_FLAGS(oI1_MMU_FLAGS), .oI1_DATA(oI1_DATA),
    .oMEM_REQ(oMEM_REQ), .iMEM_LOCK(mem_lock),
    .oMEM_ORDER(oMEM_ORDER), .oMEM_MASK(oMEM_MASK), .oMEM_RW(oMEM_RW), .oMEM_TID(oMEM_TID),
    .oMEM_MMUMOD(oMEM_MMUMOD), .oMEM_PDT(oMEM_PDT), .oMEM_ADDR(oMEM_ADDR), .oMEM_DATA(oMEM_DATA),
    .iMEM_VALID(mem_valid), .iMEM_PAGEFAULT(mem_pf), .iMEM_MMU_FLAGS(mem_fl), .iMEM_DATA(mem_data)
  );

  int n_cmp = 0, n_bad = 0;

  // Model: who owns the port, beats taken this grant, last owner, and in-flight owners.
  int owner = -1, beats = 0, last = 1;
  bit q[$];
  int rem [2];
  bit acc_now, pop_now;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mem_req_t rand_req();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[118:0];
  endfunction

  task automatic check_cycle();
    bit full, emr, ev0, ev1;
    bit rq [2];
    mem_req_t exp_p, got_p;
    logic [92:0] exp_r;
    #2;
    rq[0] = d0_req; rq[1] = i1_req;
    full    = (q.size() >= DEPTH);
    emr     = (owner >= 0) && rq[owner] && !full;
    acc_now = emr && !mem_lock;
    pop_now = mem_valid && (q.size() > 0);
    ev0     = pop_now && (q[0] == 1'b0);
    ev1     = pop_now && (q[0] == 1'b1);
    exp_p   = (owner >= 0) ? pl[owner] : mem_req_t'('0);
    exp_r   = pop_now ? {mem_pf, mem_fl, mem_data} : '0;
    got_p   = {oMEM_ORDER, oMEM_MASK, oMEM_RW, oMEM_TID, oMEM_MMUMOD, oMEM_PDT, oMEM_ADDR, oMEM_DATA};
    chk("mem_req", oMEM_REQ, emr);
    chk("locks", {oD0_LOCK, oI1_LOCK},
        {owner != 0 || mem_lock || full, owner != 1 || mem_lock || full});
    chk("mem_payload", got_p, exp_p);
    chk("valids", {oD0_VALID, oI1_VALID}, {ev0, ev1});
    chk("d0_rsp", {oD0_PAGEFAULT, oD0_MMU_FLAGS, oD0_DATA}, exp_r);
    chk("i1_rsp", {oI1_PAGEFAULT, oI1_MMU_FLAGS, oI1_DATA}, exp_r);
  endtask

  task automatic advance();
    int o;
    o = owner;
    @(posedge iCLOCK);
    if (inRESET) begin
      if (pop_now) void'(q.pop_front());
      if (acc_now) q.push_back(owner[0]);
      if (owner < 0) begin
        if (d0_req && i1_req) begin
`ifdef MIST1032ISA_MEMARB_DATA_PRIORITY_EN
          owner = 0;
`else
          owner = (last == 1) ? 0 : 1;
`endif
        end else if (d0_req) owner = 0;
        else if (i1_req)     owner = 1;
      end else if (!((owner == 0) ? d0_req : i1_req) || (acc_now && beats == MAXB - 1)) begin
        last = owner; owner = -1; beats = 0;
      end else if (acc_now) begin
        beats++;
      end
    end
    #1;
    if (acc_now && o >= 0 && inRESET) begin
      pl[o] = rand_req();
      rem[o]--;
    end
    d0_req = (rem[0] > 0);
    i1_req = (rem[1] > 0);
  endtask

  task automatic do_reset();
    inRESET = 1'b0;
    owner = -1; beats = 0; last = 1; q.delete();
    rem[0] = 0; rem[1] = 0; d0_req = 0; i1_req = 0; mem_valid = 0; mem_lock = 0;
    check_cycle(); advance();
    check_cycle(); advance();
    inRESET = 1'b1;
  endtask

  task automatic start(input int x, input int n);
    rem[x] = n;
    pl[x]  = rand_req();
    if (x == 0) d0_req = 1'b1; else i1_req = 1'b1;
  endtask

  initial begin
    int cnt, first;
    logic [31:0] held;
    pl[0] = rand_req(); pl[1] = rand_req();
    rem[0] = 0; rem[1] = 0;
    #2;
    chk("rst_mem_req", oMEM_REQ, 1'b0);
    chk("rst_locks", {oD0_LOCK, oI1_LOCK}, 2'b11);
    chk("rst_mem_addr", oMEM_ADDR, 32'h0);
    do_reset();

    // D0 8-beat fill, then its 8 responses
    start(0, 8); cnt = 0;
    for (int c = 0; c < 11; c++) begin
      check_cycle();
      if (c == 0) chk("grant_latency", oMEM_REQ, 1'b0);
      cnt += int'(oMEM_REQ);
      advance();
    end
    chk("fill_beats", cnt, 8);
    check_cycle(); chk("fill_idle_lock", oD0_LOCK, 1'b1); advance();
    mem_valid = 1; cnt = 0;
    for (int c = 0; c < 8; c++) begin
      mem_data = {$urandom(), $urandom()}; mem_fl = 28'($urandom());
      check_cycle(); cnt += int'(oD0_VALID); advance();
    end
    mem_valid = 0;
    chk("fill_rsp_count", cnt, 8);

    // simultaneous first requests after reset
    do_reset(); start(0, 2); start(1, 2); first = -1;
    for (int c = 0; c < 10; c++) begin
      check_cycle();
      if (c == 1) chk("tie_d0_first", {oD0_LOCK, oI1_LOCK}, 2'b01);
      if (!oI1_LOCK && first < 0) first = c;
      advance();
    end
    chk("i1_grant_cycle", first, 5);

    // D0 holds REQ past the beat limit while I1 waits
    do_reset(); start(0, 12); start(1, 1);
    for (int c = 0; c < 12; c++) begin
      check_cycle();
`ifdef MIST1032ISA_MEMARB_DATA_PRIORITY_EN
      if (c == 10) chk("regrant_owner", {oD0_LOCK, oI1_LOCK}, 2'b01);
`else
      if (c == 10) chk("regrant_owner", {oD0_LOCK, oI1_LOCK}, 2'b10);
`endif
      advance();
    end

    // memory stall mid-burst
    do_reset(); start(0, 8); cnt = 0; held = '0;
    for (int c = 0; c < 16; c++) begin
      mem_lock = (c >= 3 && c <= 5);
      check_cycle();
      if (c == 3) held = pl[0].addr;
      if (c >= 3 && c <= 5) begin
        chk("stall_lock", oD0_LOCK, 1'b1);
        chk("stall_addr_hold", oMEM_ADDR, held);
      end
      cnt += int'(oMEM_REQ && !mem_lock);
      advance();
    end
    mem_lock = 0;
    chk("stall_burst_beats", cnt, 8);

    // fill the ID FIFO with no responses
    do_reset(); start(0, 1000);
    for (int c = 0; c < 20; c++) begin check_cycle(); advance(); end
    check_cycle();
    chk("full_mem_req", oMEM_REQ, 1'b0);
    chk("full_lock", oD0_LOCK, 1'b1);
    advance();
    mem_valid = 1;
    check_cycle();
    chk("full_pop_no_accept", oMEM_REQ, 1'b0);
    chk("full_pop_valid", oD0_VALID, 1'b1);
    advance();
    mem_valid = 0;
    check_cycle();
    chk("accept_resumes", oMEM_REQ, 1'b1);
    advance();

    // reset after 3 beats, then orphan responses
    do_reset(); start(0, 8);
    for (int c = 0; c < 4; c++) begin check_cycle(); advance(); end
    inRESET = 1'b0;
    #1;
    chk("midrst_mem_req", oMEM_REQ, 1'b0);
    chk("midrst_locks", {oD0_LOCK, oI1_LOCK}, 2'b11);
    do_reset();
    mem_valid = 1;
    for (int c = 0; c < 3; c++) begin
      check_cycle();
      chk("orphan_valid", {oD0_VALID, oI1_VALID}, 2'b00);
      advance();
    end
    mem_valid = 0;

    // randomized traffic with varying stall / response rates
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      int pv, lv;
      pv = (seg == 2 || seg == 6) ? 0 : 15 + 12 * seg;
      lv = (seg % 3) * 15;
      if (seg == 5) do_reset();
      for (int c = 0; c < 500; c++) begin
        for (int x = 0; x < 2; x++)
          if (rem[x] == 0 && $urandom_range(3) == 0) start(x, $urandom_range(1, 12));
        mem_lock  = ($urandom_range(99) < lv);
        mem_valid = ($urandom_range(99) < pv);
        mem_pf    = 1'($urandom());
        mem_fl    = 28'($urandom());
        mem_data  = {$urandom(), $urandom()};
        check_cycle();
        advance();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l1_mem_port_arbiter.md
# l1_mem_port_arbiter

Shares the single data-memory request/response port between the L1 data cache (requester 0, D0) and the L1 instruction cache (requester 1, I1). Keeps line-fill bursts atomic, routes each in-order memory response back to the requester that issued it, and back-pressures both caches through their existing LOCK inputs. Sits between the two L1 caches and the memory/MMU interface.

## Interface
Parameters:
- P_ID_DEPTH, 16, depth of the outstanding-request ID FIFO (power of two)
- P_MAX_BEAT, 8, maximum accepted requests per grant

Ports:
- iCLOCK  in  1  clock
- inRESET  in  1  asynchronous, active-low reset
- iD0_REQ / iI1_REQ  in  1  request strobe per requester
- oD0_LOCK / oI1_LOCK  out  1  request not accepted this cycle; requester holds REQ and payload
- iD0_ORDER/MASK/RW/TID/MMUMOD/PDT/ADDR/DATA  in  2/4/1/14/2/32/32/32  D0 payload
- iI1_ORDER/MASK/RW/TID/MMUMOD/PDT/ADDR/DATA  in  same widths  I1 payload
- oD0_VALID / oI1_VALID  out  1  routed response strobe
- oD0_PAGEFAULT, oD0_MMU_FLAGS, oD0_DATA (and I1 equivalents)  out  1/28/64  routed response payload
- oMEM_REQ  out  1  request to memory
- iMEM_LOCK  in  1  memory not accepting
- oMEM_ORDER/MASK/RW/TID/MMUMOD/PDT/ADDR/DATA  out  2/4/1/14/2/32/32/32  muxed payload of current owner
- iMEM_VALID, iMEM_PAGEFAULT, iMEM_MMU_FLAGS, iMEM_DATA  in  1/1/28/64  in-order memory response

## Operation
- States: IDLE, GRANT_D0, GRANT_I1 (2-bit register). Beat counter b_beat (3 bits), last-owner bit b_last.
- IDLE: no REQ -> stay. One REQ -> grant it. Both -> grant the requester that is not b_last (round robin).
- GRANT_x: accept = iX_REQ && !iMEM_LOCK && !fifo_full. On accept: push owner ID, b_beat+1.
- GRANT_x -> IDLE when owner REQ low, or on accept with b_beat == P_MAX_BEAT-1. On leaving: b_beat <= 0, b_last <= x.
- oMEM_REQ = GRANT_x && iX_REQ && !fifo_full. Payload muxed from owner; zero when IDLE.
- oX_LOCK = !(GRANT_x) || iMEM_LOCK || fifo_full.
- Response: iMEM_VALID pops FIFO head; head ID selects which oX_VALID pulses; payload driven to both requesters, VALID only to one.
- Writes (RW=0) also push an ID; their ack is routed identically.
- Simultaneous push/pop: count unchanged, both pointers advance. Pop on empty FIFO: response discarded, no VALID.
- Full (count == P_ID_DEPTH): no accept; pop in same cycle does not enable accept until next cycle.

## Timing
- Reset: state IDLE, b_beat 0, b_last 1 (D0 wins first tie), FIFO empty; oMEM_REQ 0, oD0_LOCK/oI1_LOCK 1, oX_VALID 0, all payload outputs 0.
- Grant latency: REQ sampled in IDLE -> GRANT next cycle -> earliest oMEM_REQ one cycle after first REQ.
- Burst end to next grant: one IDLE cycle minimum.
- Response path combinational: oX_VALID same cycle as iMEM_VALID.
- Reset mid-burst: FIFO flushed; responses to pre-reset requests are discarded as orphans.

## Configuration
- MIST1032ISA_MEMARB_DATA_PRIORITY_EN defined: in IDLE with both REQ, D0 always wins; b_last ignored.
- Undefined: round robin as above.

## Structure
- Shared package/header: state encodings, requester IDs (D0=0, I1=1), P_MAX_BEAT and P_ID_DEPTH defaults.
- One sub-module: l1_mem_port_arbiter_id_fifo (1-bit wide, P_ID_DEPTH deep, count-based full/empty).

## Test plan
- D0 8-beat read fill, I1 idle, iMEM_LOCK 0 -> 8 consecutive oMEM_REQ, 8 responses all on oD0_VALID, state returns IDLE.
- D0 and I1 REQ in same cycle after reset -> D0 granted first; after D0 drops REQ, I1 granted after one IDLE cycle.
- D0 holds REQ for 12 cycles -> grant released after beat 8; I1 waiting gets next grant (macro undefined); with macro and D0 still requesting, D0 regranted.
- iMEM_LOCK high 3 cycles mid-burst -> owner LOCK high, no push, ADDR held; burst resumes and completes 8 beats.
- 16 accepted reads, no responses -> oMEM_REQ 0, owner LOCK 1; one iMEM_VALID -> next cycle accept resumes.
- inRESET asserted after 3 beats -> outputs at reset values; later iMEM_VALID produces no oX_VALID.
